// File: rtl/seq_addsub_unit.sv
// seq_addsub_unit: multi-cycle add/subtract unit working CHUNK bits per clock
// with a registered inter-slice carry, valid/ready handshakes and status flags.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready              request handshake
//   in_a, in_b, in_op, in_cin      operands, op (00 ADD 01 SUB 10 ADC 11 SBB), carry/borrow in
//   out_valid/out_ready            result handshake
//   out_result                     A + B' + c0 modulo 2^WIDTH
//   out_carry, out_borrow          carry out of MSB; inverted carry for SUB/SBB
//   out_overflow, out_zero, out_neg  signed overflow, zero result, result MSB
// Optional (macro ADDSUB_CMP_EN): out_lt_u, out_lt_s compare flags for SUB/SBB.
module seq_addsub_unit #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_borrow,
    output logic             out_overflow,
    output logic             out_zero,
`ifdef ADDSUB_CMP_EN
    output logic             out_lt_u,
    output logic             out_lt_s,
`endif
    output logic             out_neg
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    // Reject configurations where the slices do not tile the operand exactly.
    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("seq_addsub_unit: WIDTH must be an integer multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;       // already-conditioned B'
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic               sub_q, sub_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ready_d, valid_d;
    logic               cout_d, borrow_d, ovf_d, zero_d, neg_d;
`ifdef ADDSUB_CMP_EN
    logic               lt_u_d, lt_s_d;
`endif
    logic               c0_c;
    logic [CHUNK-1:0]   a_sl_c, b_sl_c;
    logic [CHUNK:0]     sum_c;

    assign out_result = res_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            carry_q      <= 1'b0;
            sub_q        <= 1'b0;
            idx_q        <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_carry    <= 1'b0;
            out_borrow   <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
            out_neg      <= 1'b0;
`ifdef ADDSUB_CMP_EN
            out_lt_u     <= 1'b0;
            out_lt_s     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            carry_q      <= carry_d;
            sub_q        <= sub_d;
            idx_q        <= idx_d;
            in_ready     <= ready_d;
            out_valid    <= valid_d;
            out_carry    <= cout_d;
            out_borrow   <= borrow_d;
            out_overflow <= ovf_d;
            out_zero     <= zero_d;
            out_neg      <= neg_d;
`ifdef ADDSUB_CMP_EN
            out_lt_u     <= lt_u_d;
            out_lt_s     <= lt_s_d;
`endif
        end
    end

    // Next-state, slice adder and flag generation.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        carry_d  = carry_q;
        sub_d    = sub_q;
        idx_d    = idx_q;
        cout_d   = out_carry;
        borrow_d = out_borrow;
        ovf_d    = out_overflow;
        zero_d   = out_zero;
        neg_d    = out_neg;
`ifdef ADDSUB_CMP_EN
        lt_u_d   = out_lt_u;
        lt_s_d   = out_lt_s;
`endif

        // Initial carry: ADD 0, SUB 1, ADC cin, SBB ~cin.
        unique case (in_op)
            2'b00:   c0_c = 1'b0;
            2'b01:   c0_c = 1'b1;
            2'b10:   c0_c = in_cin;
            default: c0_c = ~in_cin;
        endcase

        a_sl_c = a_q[32'(idx_q) * CHUNK +: CHUNK];
        b_sl_c = b_q[32'(idx_q) * CHUNK +: CHUNK];
        sum_c  = {1'b0, a_sl_c} + {1'b0, b_sl_c} + (CHUNK + 1)'(carry_q);

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = in_op[0] ? ~in_b : in_b;
                    carry_d = c0_c;
                    sub_d   = in_op[0];
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[32'(idx_q) * CHUNK +: CHUNK] = sum_c[CHUNK-1:0];
                carry_d = sum_c[CHUNK];
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    // Flags come from the full result including the slice written now.
                    idx_d    = '0;
                    cout_d   = sum_c[CHUNK];
                    borrow_d = sub_q & ~sum_c[CHUNK];
                    ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                               (res_d[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d   = (res_d == '0);
                    neg_d    = res_d[WIDTH-1];
`ifdef ADDSUB_CMP_EN
                    lt_u_d   = sub_q & ~sum_c[CHUNK];
                    lt_s_d   = sub_q & (res_d[WIDTH-1] ^ ovf_d);
`endif
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Testbench for seq_addsub_unit: directed corner cases, backpressure, reset
// abort and randomized operations checked against an arithmetic reference model.
module tb_seq_addsub_unit #(
    parameter int unsigned W = 64,
    parameter int unsigned C = 16
);

    localparam int unsigned N = W / C;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [1:0]   in_op;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_carry;
    logic         out_borrow;
    logic         out_overflow;
    logic         out_zero;
    logic         out_neg;
`ifdef ADDSUB_CMP_EN
    logic         out_lt_u;
    logic         out_lt_s;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Expected values from the reference model.
    logic [W-1:0] e_res;
    logic e_carry, e_borrow, e_ovf, e_zero, e_neg, e_ltu, e_lts;

    seq_addsub_unit #(.WIDTH(W), .CHUNK(C)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_op        (in_op),
        .in_cin       (in_cin),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_borrow   (out_borrow),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
`ifdef ADDSUB_CMP_EN
        .out_lt_u     (out_lt_u),
        .out_lt_s     (out_lt_s),
`endif
        .out_neg      (out_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned and sign-extended arithmetic on the whole operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op, input logic cin);
        logic         sub;
        logic         use_cin;
        logic [W-1:0] bp;
        logic         c0;
        logic         bin;
        logic [W:0]   u;
        logic [W+1:0] s;
        logic [W+1:0] sa;
        logic [W+1:0] sb;
        sub     = op[0];
        use_cin = op[1];
        bp      = sub ? ~b : b;
        c0      = use_cin ? (sub ? ~cin : cin) : sub;
        u       = {1'b0, a} + {1'b0, bp} + (W + 1)'(c0);
        s       = {{2{a[W-1]}}, a} + {{2{bp[W-1]}}, bp} + (W + 2)'(c0);
        e_res    = u[W-1:0];
        e_carry  = u[W];
        e_borrow = sub & ~u[W];
        e_ovf    = (s[W+1:W-1] != {3{s[W-1]}});
        e_zero   = (e_res == '0);
        e_neg    = e_res[W-1];
        // Compare flags: A < B + borrow_in, unsigned and signed.
        bin   = sub & use_cin & cin;
        sa    = {{2{a[W-1]}}, a};
        sb    = {{2{b[W-1]}}, b} + (W + 2)'(bin);
        e_ltu = sub & (({1'b0, a}) < ({1'b0, b} + (W + 1)'(bin)));
        e_lts = sub & ($signed(sa) < $signed(sb));
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input logic cin);
        int t;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk1("send_ready", in_ready, 1'b1);
        model(a, b, op, cin);
        in_a = a; in_b = b; in_op = op; in_cin = cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble inputs after accept; they must have no effect.
        in_a   = W'({$urandom, $urandom});
        in_b   = W'({$urandom, $urandom});
        in_op  = 2'($urandom);
        in_cin = 1'($urandom);
        chk1("accepted", in_ready, 1'b0);
    endtask

    task automatic wait_valid(input string tag);
        int lat;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, W'(lat), W'(N));
    endtask

    task automatic check_out(input string tag);
        chk ({tag, "_result"},   out_result,   e_res);
        chk1({tag, "_carry"},    out_carry,    e_carry);
        chk1({tag, "_borrow"},   out_borrow,   e_borrow);
        chk1({tag, "_overflow"}, out_overflow, e_ovf);
        chk1({tag, "_zero"},     out_zero,     e_zero);
        chk1({tag, "_neg"},      out_neg,      e_neg);
`ifdef ADDSUB_CMP_EN
        chk1({tag, "_lt_u"},     out_lt_u,     e_ltu);
        chk1({tag, "_lt_s"},     out_lt_s,     e_lts);
`endif
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk1({tag, "_valid_drop"}, out_valid, 1'b0);
        chk1({tag, "_ready_back"}, in_ready, 1'b1);
    endtask

    logic [W-1:0] ones;
    logic [W-1:0] max_pos;
    logic [W-1:0] min_neg;
    logic [W-1:0] snap_res;
    logic         snap_flags;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    initial begin
        ones    = '1;
        max_pos = '1;
        max_pos[W-1] = 1'b0;
        min_neg = '0;
        min_neg[W-1] = 1'b1;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_op = OP_ADD; in_cin = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_valid", out_valid, 1'b0);
        chk ("rst_result", out_result, '0);
        chk1("rst_carry", out_carry, 1'b0);
        chk1("rst_zero", out_zero, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk1("rst_ready", in_ready, 1'b1);

        // Basic subtract.
        send(W'(10), W'(3), OP_SUB, 1'b0);
        wait_valid("sub_basic");
        check_out("sub_basic");
        chk("sub_basic_const", out_result, W'(7));
        release_out("sub_basic");

        // 0 - 1 wraps to all ones with borrow.
        send('0, W'(1), OP_SUB, 1'b0);
        wait_valid("sub_wrap");
        check_out("sub_wrap");
        chk ("sub_wrap_const", out_result, ones);
        chk1("sub_wrap_borrow", out_borrow, 1'b1);
        release_out("sub_wrap");

        // Signed overflow on max positive + 1.
        send(max_pos, W'(1), OP_ADD, 1'b0);
        wait_valid("add_ovf");
        check_out("add_ovf");
        chk ("add_ovf_const", out_result, min_neg);
        chk1("add_ovf_flag", out_overflow, 1'b1);
        release_out("add_ovf");

        // Carry ripples through every slice.
        send(ones, '0, OP_ADC, 1'b1);
        wait_valid("adc_wrap");
        check_out("adc_wrap");
        chk1("adc_wrap_zero", out_zero, 1'b1);
        chk1("adc_wrap_carry", out_carry, 1'b1);
        release_out("adc_wrap");

        send(W'(5), W'(5), OP_SBB, 1'b1);
        wait_valid("sbb_b1");
        check_out("sbb_b1");
        chk("sbb_b1_const", out_result, ones);
        release_out("sbb_b1");

        send(W'(5), W'(5), OP_SBB, 1'b0);
        wait_valid("sbb_b0");
        check_out("sbb_b0");
        chk1("sbb_b0_zero", out_zero, 1'b1);
        release_out("sbb_b0");

        // Backpressure: outputs hold, new requests ignored.
        send(W'(1234), W'(99), OP_ADD, 1'b0);
        wait_valid("bp");
        check_out("bp");
        snap_res   = out_result;
        snap_flags = out_carry;
        in_a = W'(40); in_b = W'(2); in_op = OP_ADD; in_cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk ("bp_hold_result", out_result, snap_res);
            chk1("bp_hold_carry", out_carry, snap_flags);
            chk1("bp_hold_valid", out_valid, 1'b1);
            chk1("bp_hold_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk1("bp_release_valid", out_valid, 1'b0);
        chk1("bp_release_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        chk1("bp_next_accept", in_ready, 1'b0);
        in_valid = 1'b0;
        model(W'(40), W'(2), OP_ADD, 1'b0);
        wait_valid("bp_next");
        check_out("bp_next");
        release_out("bp_next");

        // Reset in the middle of RUN aborts the operation.
        send(W'(777), W'(111), OP_ADD, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk1("rst_run_valid", out_valid, 1'b0);
        chk ("rst_run_result", out_result, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk1("rst_run_ready", in_ready, 1'b1);
        chk1("rst_run_novalid", out_valid, 1'b0);
        send(W'(1), W'(1), OP_ADD, 1'b0);
        wait_valid("post_rst");
        check_out("post_rst");
        chk("post_rst_const", out_result, W'(2));

        // Reset while DONE drops out_valid immediately.
        rst_n = 1'b0;
        #1;
        chk1("rst_done_valid", out_valid, 1'b0);
        chk1("rst_done_zero", out_zero, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk1("rst_done_ready", in_ready, 1'b1);

        // Randomized operations with random output backpressure.
        for (int i = 0; i < 30; i++) begin
            ra = W'({$urandom, $urandom});
            rb = W'({$urandom, $urandom});
            if ($urandom_range(0, 4) == 0) ra = ones;
            if ($urandom_range(0, 4) == 0) rb = min_neg;
            if ($urandom_range(0, 5) == 0) rb = ra;
            send(ra, rb, 2'($urandom), 1'($urandom));
            wait_valid("rand");
            check_out("rand");
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                chk1("rand_hold_valid", out_valid, 1'b1);
            end
            release_out("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_addsub_unit.md
Name: seq_addsub_unit

Overview:
- Parametrised, multi-cycle integer add/subtract unit; successor to the fixed 64-bit combinational subtractor.
- Processes operands in CHUNK-bit slices, one slice per clock, with a registered inter-slice carry. Supports add, subtract, add-with-carry and subtract-with-borrow.
- Sits behind the execute stage as a shared arithmetic resource with valid/ready handshakes on both sides. Also produces status flags.

Parameters:
- WIDTH, 64, operand/result width in bits.
- CHUNK, 16, slice width processed per cycle. WIDTH must be an integer multiple of CHUNK; elaboration fails otherwise.
- NCHUNK is derived as WIDTH/CHUNK and is not user-settable.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 SBB.
- in_cin  in  1  carry-in for ADC; borrow-in for SBB; ignored for ADD/SUB.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  sum/difference, modulo 2^WIDTH.
- out_carry  out  1  carry out of MSB of the internal A + B' + c0.
- out_borrow  out  1  ~out_carry for SUB/SBB; 0 for ADD/ADC.
- out_overflow  out  1  signed overflow.
- out_zero  out  1  out_result == 0.
- out_neg  out  1  out_result[WIDTH-1].

Behaviour:
- Arithmetic rule: result = A + B' + c0.
  - ADD: B' = B, c0 = 0.
  - ADC: B' = B, c0 = in_cin.
  - SUB: B' = ~B, c0 = 1.
  - SBB: B' = ~B, c0 = ~in_cin.
  - Overflow = (A[msb] == B'[msb]) && (result[msb] != A[msb]).
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1, out_valid=0.
  - On the edge where in_valid && in_ready: latch A, B', c0 and op; clear slice index to 0; go to RUN.
- RUN: in_ready=0.
  - Each cycle, add slice [idx*CHUNK +: CHUNK] of A and B' with the carry register.
  - On the edge: write the result slice, update the carry register, increment idx.
  - At the edge where idx == NCHUNK-1: compute flags from the full result; go to DONE.
- DONE: out_valid=1, outputs stable, in_ready=0.
  - On the edge where out_valid && out_ready: go to IDLE.
  - in_ready is high in the following cycle. There is no same-cycle turnaround.
- Latency: out_valid rises exactly NCHUNK edges after the accepting edge. This is 4 at defaults and 1 when CHUNK == WIDTH.
- Throughput: one operation per NCHUNK+2 cycles when out_ready is held high.
- Inputs in_a, in_b, in_op and in_cin are sampled only at the accept edge. Later changes have no effect.
- Backpressure: with out_ready low, DONE holds indefinitely with all outputs constant.
- Reset (async, rst_n=0): state=IDLE, in_ready=1 after release, out_valid=0, all outputs zero, carry register and idx = 0.
  - Reset asserted mid-RUN or in DONE aborts the operation; no partial result is ever presented.
- in_valid while not in IDLE is ignored, because in_ready is low.
- Wrap-around: the result is truncated to WIDTH. Examples at WIDTH=64:
  - 0xFFFF_FFFF_FFFF_FFFF + 1 gives result 0, carry=1, zero=1.
  - 0 - 1 gives all-ones, borrow=1.

Optional Feature:
- Macro: ADDSUB_CMP_EN.
- When defined: adds outputs out_lt_u (1 bit) and out_lt_s (1 bit), valid with out_valid and reset to 0.
  - out_lt_u = borrow of A - B.
  - out_lt_s = out_neg XOR out_overflow of A - B.
  - Both are meaningful only for SUB and SBB, and are forced to 0 for ADD and ADC.
- When undefined: these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Defaults, SUB, A=10, B=3, out_ready=1 -> out_valid exactly 4 edges after accept; result=7, borrow=0, zero=0, overflow=0.
- SUB, A=0, B=1 -> result=0xFFFF_FFFF_FFFF_FFFF, borrow=1, neg=1; with ADDSUB_CMP_EN: lt_u=1, lt_s=1.
- ADD, A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> result=0x8000_0000_0000_0000, overflow=1, carry=0. ADC, A=all-ones, B=0, cin=1 -> result=0, carry=1, zero=1.
- SBB, A=5, B=5, cin=1 -> result=all-ones, borrow=1. Repeat with cin=0 -> result=0, zero=1. Confirms that the carry crosses every slice boundary.
- Hold out_ready=0 for 10 cycles in DONE -> outputs constant, in_ready=0, new in_valid ignored. Raise out_ready -> IDLE, next request accepted one cycle later.
- Assert rst_n=0 at RUN idx=2 -> out_valid=0 immediately, in_ready=1 after release; next request A=1, B=1 ADD returns exactly 2. Re-run the suite with CHUNK=64 (latency 1) and with WIDTH=32, CHUNK=8.
